// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported SRAM bus between instruction fetch and the load/store unit.
// One transaction in flight; data wins unless fetch has been starved for STARVE_LIMIT grants.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_req_ready,
    input  logic                    if_flush,
    output logic                    if_resp_valid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    mem_req,
    input  logic                    mem_we,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    mem_req_ready,
    output logic                    mem_resp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH/8-1:0] bus_wstrb,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_gnt,
    input  logic                    bus_rvalid,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t     state_q, state_d;
    logic       owner_if_q, owner_if_d;
    logic [3:0] streak_q, streak_d;
    logic       drop_q, drop_d;
    logic       sel_if;
    logic       grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_if_q <= 1'b0;
            streak_q   <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_if_q <= owner_if_d;
            streak_q   <= streak_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_if_d     = owner_if_q;
        streak_d       = streak_q;
        drop_d         = drop_q;
        sel_if         = owner_if_q;
        bus_req        = 1'b0;
        if_resp_valid  = 1'b0;
        mem_resp_valid = 1'b0;
        grant          = 1'b0;

        // Outputs stay quiet while reset is held, even if the state is mid-transaction.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    sel_if  = if_req && (!mem_req || streak_q == LIMIT);
                    bus_req = if_req || mem_req;
                    if (bus_req) begin
                        owner_if_d = sel_if;
                        state_d    = bus_gnt ? WAIT : ISSUE;
                        if (bus_gnt && sel_if && if_flush) drop_d = 1'b1;
                    end
                end
                ISSUE: begin
                    bus_req = 1'b1;
                    if (bus_gnt) state_d = WAIT;
                    if (owner_if_q && if_flush) drop_d = 1'b1;
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        state_d = IDLE;
                        if (owner_if_q) begin
                            if_resp_valid = !drop_q && !if_flush;
                            drop_d        = 1'b0;
                        end else begin
                            mem_resp_valid = 1'b1;
                        end
                    end else if (owner_if_q && if_flush) begin
                        drop_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            grant = bus_req && bus_gnt;
            if (grant) begin
                if (sel_if || !if_req) streak_d = '0;
                else if (streak_q < LIMIT) streak_d = streak_q + 4'd1;
            end
        end
    end

    assign if_req_ready  = grant && sel_if;
    assign mem_req_ready = grant && !sel_if;

    // Fetch never writes; payload lines are zeroed whenever they carry nothing meaningful.
    assign bus_we    = bus_req && !sel_if && mem_we;
    assign bus_addr  = !bus_req ? '0 : (sel_if ? if_addr : mem_addr);
    assign bus_wstrb = bus_we ? mem_wstrb : '0;
    assign bus_wdata = bus_we ? mem_wdata : '0;

    assign if_rdata  = if_resp_valid  ? bus_rdata : '0;
    assign mem_rdata = mem_resp_valid ? bus_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified SRAM bus between the IF-stage instruction fetch and the MEM-stage load/store unit.
- Enforces one outstanding transaction at a time.
- Fixed data-over-instruction priority, with an anti-starvation guard for instruction fetch.
- Drops instruction responses invalidated by branch_taken_cancel from ID.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, bus data width
STARVE_LIMIT, 4, consecutive data grants with a fetch waiting before fetch is forced to win (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request valid
if_addr  in  ADDR_WIDTH  fetch address
if_req_ready  out  1  fetch request accepted this cycle
if_flush  in  1  discard any pending or outstanding fetch response (branch_taken_cancel)
if_resp_valid  out  1  fetch data valid, one-cycle pulse
if_rdata  out  DATA_WIDTH  fetch data
mem_req  in  1  data request valid
mem_we  in  1  1 = store
mem_addr  in  ADDR_WIDTH  data address
mem_wstrb  in  DATA_WIDTH/8  byte strobes, stores only
mem_wdata  in  DATA_WIDTH  store data
mem_req_ready  out  1  data request accepted this cycle
mem_resp_valid  out  1  load data or store ack, one-cycle pulse
mem_rdata  out  DATA_WIDTH  load data
bus_req  out  1  request to SRAM
bus_we  out  1  write enable
bus_addr  out  ADDR_WIDTH  address
bus_wstrb  out  DATA_WIDTH/8  byte strobes, 0 on reads
bus_wdata  out  DATA_WIDTH  write data
bus_gnt  in  1  SRAM accepts bus_req this cycle
bus_rvalid  in  1  response valid, at least 1 cycle after the grant
bus_rdata  in  DATA_WIDTH  response data

Behaviour:
- Reset: state IDLE, owner=none, streak=0, drop=0. All outputs 0.
- States:
  - IDLE: select owner combinationally. Drive bus_req when if_req or mem_req.
    - Rule: mem wins unless if_req && streak==STARVE_LIMIT.
    - bus_gnt=1 → WAIT (owner registered). bus_gnt=0 → ISSUE (owner locked).
  - ISSUE: bus_req=1 with the locked owner's payload, which the requester holds stable. No re-arbitration. bus_gnt → WAIT.
  - WAIT: bus_req=0. bus_rvalid → pulse the owner's resp_valid and rdata, then → IDLE.
- Acceptance: x_req_ready = bus_req && bus_gnt && owner==x. Combinational; only one ready per cycle.
- Payload: bus_* muxed from the owner. Fetch forces bus_we=0 and bus_wstrb=0.
- Throughput: at most one transaction per 2 cycles (grant in cycle N, rvalid in N+1 or later, next grant no earlier than the cycle after rvalid). No new request is issued in the rvalid cycle.
- Streak counter, updated at each grant:
  - mem granted while if_req=1: streak+1, saturating at STARVE_LIMIT.
  - fetch granted: streak=0.
  - mem granted with if_req=0: streak=0.
- Flush: if_flush with owner=IF in ISSUE or WAIT (including the granting cycle) sets drop=1.
  - A fetch in ISSUE is still issued; its eventual response is suppressed (if_resp_valid=0).
  - drop clears when the dropped response returns.
  - if_flush coinciding with bus_rvalid for IF suppresses that pulse.
  - if_flush in IDLE: no effect on state; if_req_ready is still governed only by the handshake.
  - if_flush has no effect on mem transactions.
- rdata outputs present bus_rdata combinationally. Only meaningful while the matching resp_valid is 1.
- Any bus_rvalid seen in IDLE or ISSUE is ignored.
- rst mid-transaction: return to IDLE. A late bus_rvalid is ignored, and the requester re-issues.
- mem_resp_valid fires for stores too; mem_rdata is don't-care for stores.

Test Plan:
- Lone fetch: if_req, addr 0x100, gnt same cycle; rvalid next cycle, rdata 0x00000013 → if_req_ready in cycle 0, if_resp_valid+0x13 in cycle 1, bus_we=0, bus_wstrb=0.
- Simultaneous if_req and mem_req (store addr 0x2000, wstrb 0xF, wdata 0xDEADBEEF) → mem granted first with bus_we=1 and its payload, mem_resp_valid on rvalid; fetch granted in the next IDLE.
- Starvation: mem_req and if_req held continuously, STARVE_LIMIT=4 → grants M,M,M,M,I,M…; streak resets to 0 after the fetch grant.
- Delayed grant: bus_gnt low 3 cycles with fetch pending, then mem_req rises → state stays ISSUE for the fetch, bus_addr stable, mem not granted until the fetch completes.
- Flush: fetch granted, if_flush in WAIT, rvalid 2 cycles later → no if_resp_valid, drop cleared; a following fetch returns normally.
- Reset during WAIT, then bus_rvalid the cycle after reset → all outputs 0, no resp_valid, state IDLE.
